// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and helpers for the BTB/RAS branch predictor
// Purpose: control-flow type encoding and saturating counter helpers.
// Ports: none (package).
package bp_pkg;

  typedef enum logic [1:0] {
    BRANCH = 2'd0,
    JUMP   = 2'd1,
    RET    = 2'd2
  } br_type_e;

  // Counter helpers work on a fixed wide word; callers cast to their own width.
  localparam int SAT_W = 16;

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                               input logic [SAT_W-1:0] max_v);
    return (v >= max_v) ? max_v : v + SAT_W'(1);
  endfunction

  function automatic logic [SAT_W-1:0] sat_dec(input logic [SAT_W-1:0] v);
    return (v == '0) ? '0 : v - SAT_W'(1);
  endfunction

endpackage

// File: rtl/bp_ras.sv
// rtl/bp_ras.sv - circular return-address stack with push/pop/replace
// Purpose: non-speculative RAS; oldest entry is overwritten on overflow.
// Ports:
//   clk_i, rst_i      clock, async active-high reset
//   push_i, pop_i     push data_i / pop; both together replace the top
//   data_i            return address to push
//   top_o             current top of stack (undefined when empty)
//   empty_o, full_o   occupancy flags
module bp_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o,
  output logic            full_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [XLEN-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q;     // next free slot
  logic [PTR_W:0]   occ_q;
  logic [PTR_W-1:0] top_ptr;
  logic             do_push;
  logic             do_pop;
  logic             do_replace;

  assign top_ptr = ptr_q - PTR_W'(1);
  assign top_o   = mem_q[top_ptr];
  assign empty_o = (occ_q == '0);
  assign full_o  = (occ_q == (PTR_W+1)'(RAS_DEPTH));

  // A replace on an empty stack has nothing to replace, so it becomes a push.
  assign do_replace = push_i & pop_i & ~empty_o;
  assign do_push    = push_i & (~pop_i | empty_o);
  assign do_pop     = pop_i & ~push_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (do_push) begin
        mem_q[ptr_q] <= data_i;
      end else if (do_replace) begin
        mem_q[top_ptr] <= data_i;
      end
    end
  end

  // When full, ptr_q already points at the oldest entry, so a push overwrites it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      occ_q <= '0;
    end else if (do_push) begin
      ptr_q <= ptr_q + PTR_W'(1);
      if (!full_o) occ_q <= occ_q + (PTR_W+1)'(1);
    end else if (do_pop) begin
      ptr_q <= top_ptr;
      occ_q <= occ_q - (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/bp_btb_ras.sv
// rtl/bp_btb_ras.sv - direct-mapped BTB with saturating counters plus RAS
// Purpose: IF-stage next-PC prediction, EX-stage training, mispredict detect
//          and performance counting.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   f_pc_i                       fetch PC
//   f_hit_o/f_taken_o/f_pred_pc_o lookup result (combinational)
//   ex_valid_i .. ex_pred_pc_i   resolved control-flow instruction from EX
//   mispredict_o, redirect_pc_o  flush request and correct next PC
//   perf_branches_o/perf_mispred_o saturating event counters
module bp_btb_ras
  import bp_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 64,
  parameter int CNT_W     = 2,
  parameter int RAS_DEPTH = 8,
  parameter int PERF_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [XLEN-1:0]   f_pc_i,
  output logic              f_hit_o,
  output logic              f_taken_o,
  output logic [XLEN-1:0]   f_pred_pc_o,
  input  logic              ex_valid_i,
  input  logic [XLEN-1:0]   ex_pc_i,
  input  br_type_e          ex_type_i,
  input  logic              ex_is_call_i,
  input  logic              ex_taken_i,
  input  logic [XLEN-1:0]   ex_target_i,
  input  logic [XLEN-1:0]   ex_pred_pc_i,
  output logic              mispredict_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic [PERF_W-1:0] perf_branches_o,
  output logic [PERF_W-1:0] perf_mispred_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [XLEN-1:0]   target;
    br_type_e          br_type;
    logic [CNT_W-1:0]  cnt;
  } btb_entry_t;

  // valid/cnt carry reset; tag/target/type are qualified by valid.
  logic             valid_q  [ENTRIES];
  logic [CNT_W-1:0] cnt_q    [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  br_type_e         type_q   [ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic [XLEN-1:0]  ex_fall;
  logic             ex_wr;
  btb_entry_t       ex_new;

  logic [XLEN-1:0]  ras_top;
  logic             ras_empty;
  logic             ras_full_unused;
  logic             pc_lsb_unused;

  assign pc_lsb_unused = ^{f_pc_i[1:0], ex_pc_i[1:0]};

  // Lookup: reads the pre-update array contents, no same-cycle bypass.
  assign f_idx     = f_pc_i[IDX_W+1:2];
  assign f_tag     = f_pc_i[XLEN-1:IDX_W+2];
  assign f_hit_o   = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign f_taken_o = f_hit_o && ((type_q[f_idx] != BRANCH) || cnt_q[f_idx][CNT_W-1]);

  always_comb begin
    f_pred_pc_o = f_pc_i + XLEN'(4);
    if (f_hit_o && (type_q[f_idx] == RET) && !ras_empty) begin
      f_pred_pc_o = ras_top;
    end else if (f_taken_o) begin
      f_pred_pc_o = target_q[f_idx];
    end
  end

  // Resolution
  assign ex_fall       = ex_pc_i + XLEN'(4);
  assign redirect_pc_o = ex_taken_i ? ex_target_i : ex_fall;
  assign mispredict_o  = ex_valid_i && (redirect_pc_o != ex_pred_pc_i);

  // Training
  assign ex_idx = ex_pc_i[IDX_W+1:2];
  assign ex_tag = ex_pc_i[XLEN-1:IDX_W+2];
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  always_comb begin
    ex_wr          = 1'b0;
    ex_new.valid   = 1'b1;
    ex_new.tag     = ex_tag;
    ex_new.target  = target_q[ex_idx];
    ex_new.br_type = ex_type_i;
    ex_new.cnt     = cnt_q[ex_idx];
    if (ex_valid_i) begin
      if (ex_hit) begin
        ex_wr = 1'b1;
        if (ex_type_i == BRANCH) begin
          ex_new.cnt = ex_taken_i
                     ? CNT_W'(sat_inc(SAT_W'(cnt_q[ex_idx]), SAT_W'(CNT_MAX)))
                     : CNT_W'(sat_dec(SAT_W'(cnt_q[ex_idx])));
          if (ex_taken_i) ex_new.target = ex_target_i;
        end else begin
          ex_new.cnt    = CNT_MAX;
          ex_new.target = ex_target_i;
        end
      end else if (ex_taken_i) begin
        ex_wr         = 1'b1;
        ex_new.target = ex_target_i;
        ex_new.cnt    = (ex_type_i == BRANCH) ? CNT_WT : CNT_MAX;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= '0;
      end
    end else if (ex_wr) begin
      valid_q[ex_idx] <= ex_new.valid;
      cnt_q[ex_idx]   <= ex_new.cnt;
    end
  end

  // Gated by rst_i so a reset overlapping the edge cannot leave a stale write.
  always_ff @(posedge clk_i) begin
    if (ex_wr && !rst_i) begin
      tag_q[ex_idx]    <= ex_new.tag;
      target_q[ex_idx] <= ex_new.target;
      type_q[ex_idx]   <= ex_new.br_type;
    end
  end

  bp_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ex_valid_i && ex_is_call_i),
    .pop_i   (ex_valid_i && (ex_type_i == RET)),
    .data_i  (ex_fall),
    .top_o   (ras_top),
    .empty_o (ras_empty),
    .full_o  (ras_full_unused)
  );

  // Performance counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_branches_o <= '0;
      perf_mispred_o  <= '0;
    end else if (ex_valid_i) begin
      if (perf_branches_o != '1) perf_branches_o <= perf_branches_o + PERF_W'(1);
      if (mispredict_o && (perf_mispred_o != '1)) perf_mispred_o <= perf_mispred_o + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_bp_btb_ras.sv
// tb/tb_bp_btb_ras.sv - self-checking bench for bp_btb_ras
module tb_bp_btb_ras;
  import bp_pkg::*;

  localparam int XLEN = 32, ENTRIES = 64, CNT_W = 2, RAS_DEPTH = 2, PERF_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic [XLEN-1:0]   f_pc_i = '0;
  logic              f_hit_o, f_taken_o;
  logic [XLEN-1:0]   f_pred_pc_o;
  logic              ex_valid_i = 1'b0;
  logic [XLEN-1:0]   ex_pc_i = '0;
  br_type_e          ex_type_i = BRANCH;
  logic              ex_is_call_i = 1'b0;
  logic              ex_taken_i = 1'b0;
  logic [XLEN-1:0]   ex_target_i = '0;
  logic [XLEN-1:0]   ex_pred_pc_i = '0;
  logic              mispredict_o;
  logic [XLEN-1:0]   redirect_pc_o;
  logic [PERF_W-1:0] perf_branches_o, perf_mispred_o;

  int n_cmp = 0;
  int n_fail = 0;

  bp_btb_ras #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W), .RAS_DEPTH(RAS_DEPTH), .PERF_W(PERF_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .f_pc_i(f_pc_i), .f_hit_o(f_hit_o), .f_taken_o(f_taken_o),
    .f_pred_pc_o(f_pred_pc_o), .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i), .ex_type_i(ex_type_i),
    .ex_is_call_i(ex_is_call_i), .ex_taken_i(ex_taken_i), .ex_target_i(ex_target_i),
    .ex_pred_pc_i(ex_pred_pc_i), .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
    .perf_branches_o(perf_branches_o), .perf_mispred_o(perf_mispred_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: entries remember the full PC they were trained on.
  bit          m_valid [ENTRIES];
  logic [31:0] m_pc    [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  br_type_e    m_type  [ENTRIES];
  int          m_cnt   [ENTRIES];
  logic [31:0] m_ras   [$];
  int          m_br, m_mp;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit m_match(input logic [31:0] pc);
    int i = m_idx(pc);
    return m_valid[i] && (m_pc[i][31:2] == pc[31:2]);
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output logic hit, output logic taken,
                                   output logic [31:0] pred);
    int i = m_idx(pc);
    hit   = m_match(pc);
    taken = hit && (m_type[i] != BRANCH || m_cnt[i] >= 2);
    if (hit && m_type[i] == RET && m_ras.size() > 0) pred = m_ras[m_ras.size()-1];
    else if (taken) pred = m_tgt[i];
    else pred = pc + 32'd4;
  endfunction

  function automatic logic [31:0] m_actual();
    return ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < ENTRIES; i++) begin m_valid[i] = 0; m_cnt[i] = 0; end
    m_ras.delete();
    m_br = 0; m_mp = 0;
  endfunction

  function automatic void m_update();
    int i = m_idx(ex_pc_i);
    bit mp = (m_actual() != ex_pred_pc_i);
    if (m_match(ex_pc_i)) begin
      m_type[i] = ex_type_i;
      if (ex_type_i == BRANCH) begin
        m_cnt[i] = ex_taken_i ? (m_cnt[i] < 3 ? m_cnt[i] + 1 : 3) : (m_cnt[i] > 0 ? m_cnt[i] - 1 : 0);
        if (ex_taken_i) m_tgt[i] = ex_target_i;
      end else begin
        m_cnt[i] = 3; m_tgt[i] = ex_target_i;
      end
    end else if (ex_taken_i) begin
      m_valid[i] = 1; m_pc[i] = ex_pc_i; m_tgt[i] = ex_target_i; m_type[i] = ex_type_i;
      m_cnt[i] = (ex_type_i == BRANCH) ? 2 : 3;
    end
    if (ex_is_call_i && ex_type_i == RET) begin
      if (m_ras.size() == 0) m_ras.push_back(ex_pc_i + 32'd4);
      else m_ras[m_ras.size()-1] = ex_pc_i + 32'd4;
    end else if (ex_is_call_i) begin
      m_ras.push_back(ex_pc_i + 32'd4);
      if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
    end else if (ex_type_i == RET) begin
      if (m_ras.size() > 0) void'(m_ras.pop_back());
    end
    m_br++;
    if (mp) m_mp++;
  endfunction

  task automatic sync();
    @(posedge clk_i); #1;
  endtask

  task automatic ex_drive(input logic [31:0] pc, input br_type_e ty, input logic call,
                          input logic tkn, input logic [31:0] tgt, input logic [31:0] pred);
    ex_valid_i = 1'b1; ex_pc_i = pc; ex_type_i = ty; ex_is_call_i = call;
    ex_taken_i = tkn; ex_target_i = tgt; ex_pred_pc_i = pred;
  endtask

  task automatic ex_commit();
    if (ex_valid_i) m_update();
    @(posedge clk_i); #1;
    ex_valid_i = 1'b0;
  endtask

  task automatic ex_op(input logic [31:0] pc, input br_type_e ty, input logic call,
                       input logic tkn, input logic [31:0] tgt);
    ex_drive(pc, ty, call, tkn, tgt, pc + 32'd4);
    @(negedge clk_i);
    ex_commit();
  endtask

  task automatic test_reset();
    f_pc_i = 32'h100;
    #2 rst_i = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (f_pred_pc_o !== 32'h104) begin n_fail++; $display("FAIL rst_during_pred: got %h want 104", f_pred_pc_o); end
    @(posedge clk_i); #1 rst_i = 1'b0;
    m_reset();
    #1;
    n_cmp++; if (f_hit_o !== 1'b0) begin n_fail++; $display("FAIL rst_hit: got %b want 0", f_hit_o); end
    n_cmp++; if (f_taken_o !== 1'b0) begin n_fail++; $display("FAIL rst_taken: got %b want 0", f_taken_o); end
    n_cmp++; if (f_pred_pc_o !== 32'h104) begin n_fail++; $display("FAIL rst_pred: got %h want 104", f_pred_pc_o); end
    n_cmp++; if (perf_branches_o !== 32'd0) begin n_fail++; $display("FAIL rst_perf_br: got %0d want 0", perf_branches_o); end
    n_cmp++; if (perf_mispred_o !== 32'd0) begin n_fail++; $display("FAIL rst_perf_mp: got %0d want 0", perf_mispred_o); end
  endtask

  task automatic test_branch();
    sync();
    ex_drive(32'h100, BRANCH, 1'b0, 1'b1, 32'h80, 32'h104);
    f_pc_i = 32'h100;
    @(negedge clk_i);
    n_cmp++; if (mispredict_o !== 1'b1) begin n_fail++; $display("FAIL br_mispredict: got %b want 1", mispredict_o); end
    n_cmp++; if (redirect_pc_o !== 32'h80) begin n_fail++; $display("FAIL br_redirect: got %h want 80", redirect_pc_o); end
    n_cmp++; if (f_hit_o !== 1'b0) begin n_fail++; $display("FAIL br_no_bypass: got %b want 0", f_hit_o); end
    ex_commit();
    #1;
    n_cmp++; if (f_hit_o !== 1'b1) begin n_fail++; $display("FAIL br_hit: got %b want 1", f_hit_o); end
    n_cmp++; if (f_taken_o !== 1'b1) begin n_fail++; $display("FAIL br_taken: got %b want 1", f_taken_o); end
    n_cmp++; if (f_pred_pc_o !== 32'h80) begin n_fail++; $display("FAIL br_pred: got %h want 80", f_pred_pc_o); end
  endtask

  task automatic test_counter();
    logic [1:0]  want_taken [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] want_pred  [5] = '{32'h104, 32'h104, 32'h104, 32'h104, 32'h80};
    for (int k = 0; k < 5; k++) begin
      if (k < 3) ex_drive(32'h100, BRANCH, 1'b0, 1'b0, 32'h80, 32'h80);
      else       ex_drive(32'h100, BRANCH, 1'b0, 1'b1, 32'h80, 32'h104);
      @(negedge clk_i);
      n_cmp++; if (mispredict_o !== 1'b1) begin n_fail++; $display("FAIL cnt_mp[%0d]: got %b want 1", k, mispredict_o); end
      ex_commit();
      f_pc_i = 32'h100; #1;
      n_cmp++; if (f_taken_o !== want_taken[k][0]) begin n_fail++; $display("FAIL cnt_taken[%0d]: got %b want %b", k, f_taken_o, want_taken[k][0]); end
      n_cmp++; if (f_pred_pc_o !== want_pred[k]) begin n_fail++; $display("FAIL cnt_pred[%0d]: got %h want %h", k, f_pred_pc_o, want_pred[k]); end
    end
  endtask

  task automatic test_alias();
    ex_op(32'h200, BRANCH, 1'b0, 1'b1, 32'h300);
    f_pc_i = 32'h100; #1;
    n_cmp++; if (f_hit_o !== 1'b0) begin n_fail++; $display("FAIL alias_old_hit: got %b want 0", f_hit_o); end
    n_cmp++; if (f_pred_pc_o !== 32'h104) begin n_fail++; $display("FAIL alias_old_pred: got %h want 104", f_pred_pc_o); end
    f_pc_i = 32'h200; #1;
    n_cmp++; if (f_hit_o !== 1'b1) begin n_fail++; $display("FAIL alias_new_hit: got %b want 1", f_hit_o); end
    n_cmp++; if (f_pred_pc_o !== 32'h300) begin n_fail++; $display("FAIL alias_new_pred: got %h want 300", f_pred_pc_o); end
  endtask

  task automatic ras_check(input string name, input logic [31:0] want);
    f_pc_i = 32'h400; #1;
    n_cmp++; if (f_pred_pc_o !== want) begin n_fail++; $display("FAIL ras_%s: got %h want %h", name, f_pred_pc_o, want); end
  endtask

  task automatic test_ras();
    ex_op(32'h400, RET, 1'b0, 1'b1, 32'h500);
    ras_check("stored_only", 32'h500);
    ex_op(32'h10, JUMP, 1'b1, 1'b1, 32'h1000);
    ex_op(32'h20, JUMP, 1'b1, 1'b1, 32'h1000);
    ras_check("two_calls", 32'h24);
    ex_op(32'h400, RET, 1'b0, 1'b1, 32'h500);
    ras_check("after_pop", 32'h14);
    ex_op(32'h20, JUMP, 1'b1, 1'b1, 32'h1000);
    ex_op(32'h30, JUMP, 1'b1, 1'b1, 32'h1000);
    ras_check("overflow_top", 32'h34);
    ex_op(32'h400, RET, 1'b0, 1'b1, 32'h500);
    ras_check("overflow_pop", 32'h24);
    ex_op(32'h400, RET, 1'b0, 1'b1, 32'h500);
    ras_check("drained", 32'h500);
    ex_op(32'h400, RET, 1'b0, 1'b1, 32'h500);
    ras_check("pop_empty", 32'h500);
    ex_op(32'h60, RET, 1'b1, 1'b1, 32'h500);
    ras_check("replace_empty", 32'h64);
    ex_op(32'h10, JUMP, 1'b1, 1'b1, 32'h1000);
    ex_op(32'h70, RET, 1'b1, 1'b1, 32'h500);
    ras_check("replace_top", 32'h74);
    ex_op(32'h400, RET, 1'b0, 1'b1, 32'h500);
    ras_check("below_replace", 32'h64);
  endtask

  task automatic test_async_reset();
    sync();
    ex_drive(32'h700, BRANCH, 1'b0, 1'b1, 32'h900, 32'h704);
    f_pc_i = 32'h400;
    #3 rst_i = 1'b1;
    #1;
    n_cmp++; if (f_hit_o !== 1'b0) begin n_fail++; $display("FAIL arst_hit_now: got %b want 0", f_hit_o); end
    n_cmp++; if (f_pred_pc_o !== 32'h404) begin n_fail++; $display("FAIL arst_pred_now: got %h want 404", f_pred_pc_o); end
    n_cmp++; if (perf_branches_o !== 32'd0) begin n_fail++; $display("FAIL arst_perf_br_now: got %0d want 0", perf_branches_o); end
    @(posedge clk_i); #2;
    rst_i = 1'b0; ex_valid_i = 1'b0;
    m_reset();
    f_pc_i = 32'h700; #1;
    n_cmp++; if (f_hit_o !== 1'b0) begin n_fail++; $display("FAIL arst_no_train: got %b want 0", f_hit_o); end
    n_cmp++; if (f_pred_pc_o !== 32'h704) begin n_fail++; $display("FAIL arst_pred: got %h want 704", f_pred_pc_o); end
    n_cmp++; if (perf_branches_o !== 32'd0) begin n_fail++; $display("FAIL arst_perf_br: got %0d want 0", perf_branches_o); end
    n_cmp++; if (perf_mispred_o !== 32'd0) begin n_fail++; $display("FAIL arst_perf_mp: got %0d want 0", perf_mispred_o); end
  endtask

  function automatic logic [31:0] rand_pc();
    return 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
  endfunction

  // Each PC gets a fixed instruction kind, as in real code.
  function automatic br_type_e ty_of(input logic [31:0] pc);
    int h = (int'(pc[5:2]) + int'(pc[9:8])) % 4;
    return (h < 2) ? BRANCH : (h == 2) ? JUMP : RET;
  endfunction

  task automatic test_random();
    logic [31:0] pc, tgt, pred, fpc, ep, act;
    logic        eh, et, call, tkn, emp;
    br_type_e    ty;
    sync();
    for (int it = 0; it < 400; it++) begin
      pc   = rand_pc();
      ty   = ty_of(pc);
      call = (ty == JUMP && pc[4]) || (ty == RET && pc[6]);
      tkn  = (ty == BRANCH) ? 1'($urandom_range(0, 1)) : 1'b1;
      tgt  = 32'($urandom_range(0, 255)) << 2;
      case ($urandom_range(0, 2))
        0:       m_lookup(pc, eh, et, pred);
        1:       pred = pc + 32'd4;
        default: pred = tgt;
      endcase
      ex_drive(pc, ty, call, tkn, tgt, pred);
      if ($urandom_range(0, 4) == 0) ex_valid_i = 1'b0;
      fpc = rand_pc();
      f_pc_i = fpc;
      @(negedge clk_i);
      m_lookup(fpc, eh, et, ep);
      act = m_actual();
      emp = ex_valid_i && (act != ex_pred_pc_i);
      n_cmp++; if (f_hit_o !== eh) begin n_fail++; $display("FAIL rnd_hit[%0d] pc=%h: got %b want %b", it, fpc, f_hit_o, eh); end
      n_cmp++; if (f_taken_o !== et) begin n_fail++; $display("FAIL rnd_taken[%0d] pc=%h: got %b want %b", it, fpc, f_taken_o, et); end
      n_cmp++; if (f_pred_pc_o !== ep) begin n_fail++; $display("FAIL rnd_pred[%0d] pc=%h: got %h want %h", it, fpc, f_pred_pc_o, ep); end
      n_cmp++; if (mispredict_o !== emp) begin n_fail++; $display("FAIL rnd_mp[%0d]: got %b want %b", it, mispredict_o, emp); end
      n_cmp++; if (redirect_pc_o !== act) begin n_fail++; $display("FAIL rnd_redirect[%0d]: got %h want %h", it, redirect_pc_o, act); end
      ex_commit();
    end
    n_cmp++; if (perf_branches_o !== 32'(m_br)) begin n_fail++; $display("FAIL rnd_perf_br: got %0d want %0d", perf_branches_o, m_br); end
    n_cmp++; if (perf_mispred_o !== 32'(m_mp)) begin n_fail++; $display("FAIL rnd_perf_mp: got %0d want %0d", perf_mispred_o, m_mp); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_counter();
    test_alias();
    test_ras();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_btb_ras.md
Name: bp_btb_ras

Overview:
Parametrised branch predictor for the RV32I pipeline, succeeding the fixed single-mode predictor. Direct-mapped branch target buffer (BTB) with N-bit saturating direction counters, plus a return-address stack (RAS) for returns. Lookup is combinational off the IF-stage PC; training, RAS update and mispredict detection come from the EX stage. Also counts resolved branches and mispredicts for performance monitoring.

Parameters:
XLEN, 32, address/data width
ENTRIES, 64, BTB entries; power of 2, >=2
CNT_W, 2, direction counter width; >=1
RAS_DEPTH, 8, return-address stack entries; power of 2, >=2
PERF_W, 32, performance counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
f_pc_i  in  XLEN  fetch PC
f_hit_o  out  1  BTB tag match on f_pc_i
f_taken_o  out  1  predicted taken
f_pred_pc_o  out  XLEN  predicted next PC
ex_valid_i  in  1  EX holds a valid control-flow instruction (0 when flushed/bubble)
ex_pc_i  in  XLEN  PC of EX instruction
ex_type_i  in  2  bp_pkg::br_type_e: BRANCH, JUMP, RET
ex_is_call_i  in  1  jal/jalr with rd=x1/x5
ex_taken_i  in  1  resolved direction (1 for JUMP/RET)
ex_target_i  in  XLEN  resolved target (ALU output)
ex_pred_pc_i  in  XLEN  next PC that was predicted for this instruction, piped from IF
mispredict_o  out  1  flush request; redirect required
redirect_pc_o  out  XLEN  correct next PC
perf_branches_o  out  PERF_W  resolved control-flow count
perf_mispred_o  out  PERF_W  mispredict count

Behaviour:
- Index = pc[IDX_W+1:2], IDX_W = log2(ENTRIES). Tag = pc[XLEN-1:IDX_W+2]. pc[1:0] is ignored.
- Entry fields: valid, tag, target, type, cnt[CNT_W-1:0].
- Lookup is combinational, with no bypass from a same-cycle update; the old contents are returned.
- f_hit_o = valid & tag match.
- f_taken_o = f_hit_o & (type != BRANCH | cnt MSB).
- f_pred_pc_o selection:
  - hit, RET, RAS non-empty -> RAS top.
  - hit, RET, RAS empty -> stored target.
  - f_taken_o -> stored target.
  - otherwise -> f_pc_i+4.
- actual = ex_taken_i ? ex_target_i : ex_pc_i+4 (XLEN wrap).
- mispredict_o = ex_valid_i & (actual != ex_pred_pc_i). Combinational.
- redirect_pc_o = actual at all times.
- Training, at the clock edge when ex_valid_i:
  - Hit, BRANCH: cnt +1 if taken, else -1; saturates at 0 and 2^CNT_W-1. Target rewritten when taken.
  - Miss and taken: allocate, overwriting any prior entry. valid=1, tag, target, type. cnt = 2^(CNT_W-1) (weakly taken) for BRANCH, all-ones for JUMP/RET.
  - Miss and not taken: no allocation.
  - JUMP/RET hit: target refreshed, cnt held at all-ones.
- RAS (non-speculative, EX-driven), when ex_valid_i:
  - call only: push ex_pc_i+4.
  - RET only: pop.
  - RET and call together: replace top. Occupancy unchanged; if empty, acts as a push.
  - Push when full: circular overwrite of the oldest entry; occupancy stays RAS_DEPTH.
  - Pop when empty: no-op; occupancy stays 0.
- Perf counters, when ex_valid_i:
  - perf_branches_o +1.
  - perf_mispred_o +1 if mispredict_o.
  - Both saturate at all-ones.
- Reset (async, any time, including mid-update):
  - All valid bits 0, cnt 0, RAS pointer/occupancy 0, perf counters 0.
  - Hence f_hit_o=0, f_taken_o=0, f_pred_pc_o=f_pc_i+4 during and after reset.
  - Target/tag storage need not be reset.
- Pipeline integration: stall/flush gating stays in the hazard unit, which drives ex_valid_i=0 for bubbles. An instruction stalled in EX must present ex_valid_i for one cycle only.

Decomposition:
- bp_pkg:
  - br_type_e (BRANCH=0, JUMP=1, RET=2)
  - btb_entry_t struct, parametrised via localparam widths derived in-module
  - function sat_inc/sat_dec
- Sub-module bp_ras: circular stack with push/pop/replace, top_o, empty_o, full_o; params XLEN, RAS_DEPTH.
- Top holds BTB arrays, mispredict logic and perf counters.

Test Plan:
- Reset, then f_pc_i=0x100 -> f_hit_o=0, f_taken_o=0, f_pred_pc_o=0x104, perf counters 0.
- Taken BRANCH ex_pc=0x100, target 0x80, pred 0x104:
  - Same cycle -> mispredict_o=1, redirect 0x80.
  - Next cycle, f_pc_i=0x100 -> hit, taken, pred 0x80 (cnt=2).
- Same branch resolved not-taken twice with ENTRIES=64, CNT_W=2 -> cnt 2->1->0. Lookup gives taken=0, pred 0x104. Third not-taken holds cnt=0.
- Aliasing: train 0x100 then 0x200 (same index, ENTRIES=64) -> lookup 0x100 misses, 0x200 hits.
- RAS, with RET entry trained at 0x400:
  - Call at 0x10 (push 0x14), call at 0x20 (push 0x24) -> fetch 0x400 predicts 0x24.
  - After pop -> predicts 0x14.
  - With RAS_DEPTH=2, a third push overwrites 0x14.
  - Pop on empty -> falls back to the stored target.
- Async reset asserted mid-cycle while ex_valid_i=1 -> no training occurs, all hits cleared, perf counters 0.
